// File: rtl/l2_set_fetch_pkg.sv
// ---------------------------------------------------------------------------
// l2_set_fetch_pkg
// Shared L2 constants and types for the set-read front end: geometry
// (ways, sets, words per line), tag/way/set/state types, lookup modes and
// the round-robin victim increment helper.
// ---------------------------------------------------------------------------
package l2_set_fetch_pkg;

   localparam int L2_WAYS        = 8;
   localparam int L2_SETS        = 16;
   localparam int WORDS_PER_LINE = 4;
   localparam int L2_TAG_W       = 8;

   typedef logic [$clog2(L2_SETS)-1:0] l2_set_t;
   typedef logic [L2_TAG_W-1:0]        l2_tag_t;
   typedef logic [$clog2(L2_WAYS)-1:0] l2_way_t;
   typedef logic [1:0]                 state_t;

   // Per-word coherence states
   localparam state_t SPX_I = 2'd0;
   localparam state_t SPX_V = 2'd1;
   localparam state_t SPX_R = 2'd2;
   localparam state_t SPX_O = 2'd3;

   // Lookup request flavours carried through to the lookup stage
   localparam logic L2_LOOKUP     = 1'b0;
   localparam logic L2_LOOKUP_FWD = 1'b1;

   // Round-robin successor of a way, wrapping from the last way to way 0
   function automatic l2_way_t next_way(input l2_way_t w);
      return (w == l2_way_t'(L2_WAYS - 1)) ? '0 : w + l2_way_t'(1);
   endfunction

endpackage

// File: rtl/l2_set_fetch_evict_ptr.sv
// ---------------------------------------------------------------------------
// l2_evict_ptr
// Per-set round-robin victim pointer table.
//   clk, rst      : clock, asynchronous active-low reset (all pointers to 0)
//   adv, adv_set  : advance the pointer of adv_set by one way (wrapping)
//   rd_set        : set whose victim way is read
//   rd_way        : victim way of rd_set, already reflecting an advance of
//                   that same set in the current cycle
// ---------------------------------------------------------------------------
module l2_evict_ptr
   import l2_set_fetch_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    adv,
   input  l2_set_t adv_set,
   input  l2_set_t rd_set,
   output l2_way_t rd_way
);

   l2_way_t ptr [L2_SETS];

   // Pointer table; advances are accepted every cycle regardless of what
   // the fetch FSM is doing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < L2_SETS; i++) begin
            ptr[i] <= '0;
         end
      end else if (adv) begin
         ptr[adv_set] <= next_way(ptr[adv_set]);
      end
   end

   // Read port forwards a same-cycle advance so a capture sees the
   // post-advance victim.
   always_comb begin
      rd_way = ptr[rd_set];
      if (adv && (adv_set == rd_set)) begin
         rd_way = next_way(ptr[rd_set]);
      end
   end

endmodule

// File: rtl/l2_set_fetch.sv
// ---------------------------------------------------------------------------
// l2_set_fetch
// Set-read front end of the L2 lookup path. Accepts a set index, reads every
// way of that set from the tag/state RAM, captures the result together with
// the set's round-robin victim into holding buffers and pulses lookup_en.
// Buffers are patched by in-flight way updates until the consumer says done.
//   clk, rst            : clock, asynchronous active-low reset
//   rd_valid/rd_ready   : request handshake (rd_ready = idle)
//   rd_set/rd_tag/rd_mode: request set, tag, lookup mode
//   ram_rd_en/ram_rd_set: RAM read strobe and index
//   ram_tags/ram_states : RAM read data, valid RD_LATENCY cycles after strobe
//   tags_buf/states_buf/evict_way_buf/lookup_mode : held lookup inputs
//   lookup_en           : one-cycle pulse when the buffers become valid
//   done                : consumer releases the buffers
//   upd_*               : RAM write of one way (bypassed into the buffers)
//   evict_adv(_set)     : advance a set's victim pointer
// RD_LATENCY must lie in 1..3.
// ---------------------------------------------------------------------------
module l2_set_fetch
   import l2_set_fetch_pkg::*;
#(
   parameter int RD_LATENCY = 1
)
(
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         rd_valid,
   output logic                                         rd_ready,
   input  l2_set_t                                      rd_set,
   input  l2_tag_t                                      rd_tag,
   input  logic                                         rd_mode,
   output logic                                         ram_rd_en,
   output l2_set_t                                      ram_rd_set,
   input  l2_tag_t [L2_WAYS-1:0]                        ram_tags,
   input  state_t  [L2_WAYS-1:0][WORDS_PER_LINE-1:0]    ram_states,
   output l2_tag_t [L2_WAYS-1:0]                        tags_buf,
   output state_t  [L2_WAYS-1:0][WORDS_PER_LINE-1:0]    states_buf,
   output l2_way_t                                      evict_way_buf,
   output logic                                         lookup_en,
   output logic                                         lookup_mode,
   input  logic                                         done,
   input  logic                                         upd_en,
   input  l2_set_t                                      upd_set,
   input  l2_way_t                                      upd_way,
   input  l2_tag_t                                      upd_tag,
   input  state_t  [WORDS_PER_LINE-1:0]                 upd_states,
   input  logic                                         evict_adv,
   input  l2_set_t                                      evict_adv_set
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, CAPTURE, HOLD} fsm_t;

   fsm_t                                        state;
   logic [1:0]                                  lat_cnt;
   logic                                        hold_first;
   logic                                        pend_valid;
   l2_way_t                                     pend_way;
   l2_tag_t                                     pend_tag;
   state_t  [WORDS_PER_LINE-1:0]                pend_states;
   l2_way_t                                     victim_way;
   logic                                        upd_hit;
   l2_tag_t [L2_WAYS-1:0]                       cap_tags;
   state_t  [L2_WAYS-1:0][WORDS_PER_LINE-1:0]   cap_states;

   // The request tag only matters to the bypass matching further down the
   // pipe; it is kept on the port so the interface matches the arbiter.
   logic unused_rd_tag;
   assign unused_rd_tag = ^rd_tag;

   l2_evict_ptr u_evict_ptr (
      .clk     (clk),
      .rst     (rst),
      .adv     (evict_adv),
      .adv_set (evict_adv_set),
      .rd_set  (ram_rd_set),
      .rd_way  (victim_way)
   );

   // ram_rd_set doubles as the latched request set for the whole transaction.
   assign upd_hit   = upd_en && (upd_set == ram_rd_set);
   assign rd_ready  = (state == IDLE);
   assign ram_rd_en = (state == READ);
   assign lookup_en = (state == HOLD) && hold_first;

   // Capture data: RAM contents, overlaid by the pending update recorded
   // during the read, overlaid by a same-cycle update (newest wins).
   always_comb begin
      cap_tags   = ram_tags;
      cap_states = ram_states;
      if (pend_valid) begin
         cap_tags[pend_way]   = pend_tag;
         cap_states[pend_way] = pend_states;
      end
      if (upd_hit) begin
         cap_tags[upd_way]   = upd_tag;
         cap_states[upd_way] = upd_states;
      end
   end

   // Fetch sequencer: latch request, strobe RAM, wait out the read latency,
   // capture, then hold until the consumer releases the buffers. Updates to
   // the latched set seen while the read is in flight are parked and replayed
   // at capture; updates during HOLD patch the buffers directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         lat_cnt       <= '0;
         hold_first    <= 1'b0;
         pend_valid    <= 1'b0;
         pend_way      <= '0;
         pend_tag      <= '0;
         pend_states   <= '0;
         ram_rd_set    <= '0;
         lookup_mode   <= 1'b0;
         tags_buf      <= '0;
         states_buf    <= '0;
         evict_way_buf <= '0;
      end else begin
         case (state)
            IDLE: begin
               pend_valid <= 1'b0;
               if (rd_valid) begin
                  ram_rd_set  <= rd_set;
                  lookup_mode <= rd_mode;
                  state       <= READ;
               end
            end
            READ: begin
               if (upd_hit) begin
                  pend_valid  <= 1'b1;
                  pend_way    <= upd_way;
                  pend_tag    <= upd_tag;
                  pend_states <= upd_states;
               end
               lat_cnt <= 2'(RD_LATENCY - 1);
               state   <= (RD_LATENCY == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
               if (upd_hit) begin
                  pend_valid  <= 1'b1;
                  pend_way    <= upd_way;
                  pend_tag    <= upd_tag;
                  pend_states <= upd_states;
               end
               lat_cnt <= lat_cnt - 2'd1;
               if (lat_cnt == 2'd1) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               tags_buf      <= cap_tags;
               states_buf    <= cap_states;
               evict_way_buf <= victim_way;
               pend_valid    <= 1'b0;
               hold_first    <= 1'b1;
               state         <= HOLD;
            end
            HOLD: begin
               hold_first <= 1'b0;
               if (upd_hit) begin
                  tags_buf[upd_way]   <= upd_tag;
                  states_buf[upd_way] <= upd_states;
               end
               if (done) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_set_fetch.sv
// ---------------------------------------------------------------------------
// tb_l2_set_fetch
// Bench for l2_set_fetch with RD_LATENCY = 3. A behavioural model tracks each
// request by its acceptance cycle and derives every output from the cycle
// offset; a RAM model answers reads exactly RD_LATENCY cycles after the
// strobe and drives noise otherwise. Directed scenarios pin literal values,
// then a randomized phase runs against the model.
// ---------------------------------------------------------------------------
module tb_l2_set_fetch;
   import l2_set_fetch_pkg::*;

   localparam int LAT = 3;

   logic                                       clk = 1'b0;
   logic                                       rst = 1'b0;
   logic                                       rd_valid;
   logic                                       rd_ready;
   l2_set_t                                    rd_set;
   l2_tag_t                                    rd_tag;
   logic                                       rd_mode;
   logic                                       ram_rd_en;
   l2_set_t                                    ram_rd_set;
   l2_tag_t [L2_WAYS-1:0]                      ram_tags;
   state_t  [L2_WAYS-1:0][WORDS_PER_LINE-1:0]  ram_states;
   l2_tag_t [L2_WAYS-1:0]                      tags_buf;
   state_t  [L2_WAYS-1:0][WORDS_PER_LINE-1:0]  states_buf;
   l2_way_t                                    evict_way_buf;
   logic                                       lookup_en;
   logic                                       lookup_mode;
   logic                                       done;
   logic                                       upd_en;
   l2_set_t                                    upd_set;
   l2_way_t                                    upd_way;
   l2_tag_t                                    upd_tag;
   state_t  [WORDS_PER_LINE-1:0]               upd_states;
   logic                                       evict_adv;
   l2_set_t                                    evict_adv_set;

   l2_set_fetch #(.RD_LATENCY(LAT)) dut (
      .clk           (clk),
      .rst           (rst),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_set        (rd_set),
      .rd_tag        (rd_tag),
      .rd_mode       (rd_mode),
      .ram_rd_en     (ram_rd_en),
      .ram_rd_set    (ram_rd_set),
      .ram_tags      (ram_tags),
      .ram_states    (ram_states),
      .tags_buf      (tags_buf),
      .states_buf    (states_buf),
      .evict_way_buf (evict_way_buf),
      .lookup_en     (lookup_en),
      .lookup_mode   (lookup_mode),
      .done          (done),
      .upd_en        (upd_en),
      .upd_set       (upd_set),
      .upd_way       (upd_way),
      .upd_tag       (upd_tag),
      .upd_states    (upd_states),
      .evict_adv     (evict_adv),
      .evict_adv_set (evict_adv_set)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // RAM contents (static) and read-return schedule
   l2_tag_t [L2_WAYS-1:0]                     memTags   [L2_SETS];
   state_t  [L2_WAYS-1:0][WORDS_PER_LINE-1:0] memStates [L2_SETS];
   bit      retValid [8];
   l2_set_t retSet   [8];

   // Behavioural model
   bit                                         mBusy;
   int                                         mT;
   l2_set_t                                    mSet;
   logic                                       mMode;
   int                                         mPtr [L2_SETS];
   l2_tag_t [L2_WAYS-1:0]                      mTags;
   state_t  [L2_WAYS-1:0][WORDS_PER_LINE-1:0]  mStates;
   int                                         mEvict;
   bit                                         mPend;
   l2_way_t                                    mPendWay;
   l2_tag_t                                    mPendTag;
   state_t  [WORDS_PER_LINE-1:0]               mPendStates;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic modelReset();
      mBusy   = 1'b0;
      mT      = 0;
      mSet    = '0;
      mMode   = 1'b0;
      mTags   = '0;
      mStates = '0;
      mEvict  = 0;
      mPend   = 1'b0;
      for (int i = 0; i < L2_SETS; i++) mPtr[i] = 0;
   endtask

   // Advance the model across the coming clock edge using the inputs of
   // the current cycle.
   task automatic modelStep();
      int  rel;
      bit  hit;
      if (!rst) begin
         modelReset();
         return;
      end
      if (evict_adv) mPtr[evict_adv_set] = (mPtr[evict_adv_set] + 1) % L2_WAYS;
      hit = upd_en && (upd_set == mSet);
      rel = cyc - mT;
      if (mBusy) begin
         if (rel >= 1 && rel <= LAT) begin
            if (hit) begin
               mPend       = 1'b1;
               mPendWay    = upd_way;
               mPendTag    = upd_tag;
               mPendStates = upd_states;
            end
         end else if (rel == LAT + 1) begin
            mTags   = memTags[mSet];
            mStates = memStates[mSet];
            if (mPend) begin
               mTags[mPendWay]   = mPendTag;
               mStates[mPendWay] = mPendStates;
            end
            if (hit) begin
               mTags[upd_way]   = upd_tag;
               mStates[upd_way] = upd_states;
            end
            mPend  = 1'b0;
            mEvict = mPtr[mSet];
         end else begin
            if (hit) begin
               mTags[upd_way]   = upd_tag;
               mStates[upd_way] = upd_states;
            end
            if (done) mBusy = 1'b0;
         end
      end else if (rd_valid) begin
         mBusy = 1'b1;
         mT    = cyc;
         mSet  = rd_set;
         mMode = rd_mode;
         mPend = 1'b0;
      end
   endtask

   task automatic compareAll();
      int rel;
      rel = cyc - mT;
      checkOutput("rd_ready",      128'(rd_ready),      128'(!mBusy));
      checkOutput("ram_rd_en",     128'(ram_rd_en),     128'(mBusy && rel == 1));
      checkOutput("lookup_en",     128'(lookup_en),     128'(mBusy && rel == LAT + 2));
      checkOutput("ram_rd_set",    128'(ram_rd_set),    128'(mSet));
      checkOutput("lookup_mode",   128'(lookup_mode),   128'(mMode));
      checkOutput("tags_buf",      128'(tags_buf),      128'(mTags));
      checkOutput("states_buf",    128'(states_buf),    128'(mStates));
      checkOutput("evict_way_buf", 128'(evict_way_buf), 128'(mEvict));
   endtask

   // RAM: answer a strobe LAT cycles later, noise on all other cycles
   task automatic driveRam();
      int slot;
      if (ram_rd_en === 1'b1) begin
         slot           = (cyc + LAT) % 8;
         retValid[slot] = 1'b1;
         retSet[slot]   = ram_rd_set;
      end
      slot = cyc % 8;
      if (retValid[slot]) begin
         ram_tags       = memTags[retSet[slot]];
         ram_states     = memStates[retSet[slot]];
         retValid[slot] = 1'b0;
      end else begin
         ram_tags   = {$urandom(), $urandom()};
         ram_states = {$urandom(), $urandom()};
      end
   endtask

   // Inputs currently on the ports belong to cycle cyc; step to cyc+1 and
   // check the outputs there.
   task automatic applyStimulus();
      modelStep();
      @(negedge clk);
      cyc++;
      compareAll();
      driveRam();
   endtask

   task automatic clearInputs();
      rd_valid      = 1'b0;
      rd_set        = '0;
      rd_tag        = '0;
      rd_mode       = 1'b0;
      done          = 1'b0;
      upd_en        = 1'b0;
      upd_set       = '0;
      upd_way       = '0;
      upd_tag       = '0;
      upd_states    = '0;
      evict_adv     = 1'b0;
      evict_adv_set = '0;
   endtask

   task automatic stepN(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit sawLookup;
      for (int s = 0; s < L2_SETS; s++) begin
         memTags[s]   = {$urandom(), $urandom()};
         memStates[s] = {$urandom(), $urandom()};
      end
      for (int w = 0; w < L2_WAYS; w++) memTags[5][w] = l2_tag_t'(8'h50 + w);
      memStates[5] = 64'h5555555555555555;
      for (int i = 0; i < 8; i++) retValid[i] = 1'b0;
      ram_tags   = '0;
      ram_states = '0;
      clearInputs();
      modelReset();

      // Reset state
      rst = 1'b0;
      stepN(2);
      checkOutput("lit_reset_rd_ready",  128'(rd_ready),      128'(1));
      checkOutput("lit_reset_lookup_en", 128'(lookup_en),     128'(0));
      checkOutput("lit_reset_tags",      128'(tags_buf),      128'(0));
      checkOutput("lit_reset_evict",     128'(evict_way_buf), 128'(0));
      rst = 1'b1;
      stepN(2);

      // Basic read of set 5 (forwarding mode)
      rd_valid = 1'b1; rd_set = 5; rd_mode = L2_LOOKUP_FWD;
      applyStimulus();
      rd_valid = 1'b0;
      checkOutput("lit_ram_rd_en",  128'(ram_rd_en),  128'(1));
      checkOutput("lit_ram_rd_set", 128'(ram_rd_set), 128'(5));
      stepN(4);
      checkOutput("lit_lookup_en_T5", 128'(lookup_en),   128'(1));
      checkOutput("lit_tags_set5",    128'(tags_buf),    128'(64'h5756555453525150));
      checkOutput("lit_states_set5",  128'(states_buf),  128'(64'h5555555555555555));
      checkOutput("lit_evict_set5",   128'(evict_way_buf), 128'(0));
      checkOutput("lit_mode_fwd",     128'(lookup_mode), 128'(1));
      stepN(2);
      checkOutput("lit_hold_not_ready", 128'(rd_ready), 128'(0));
      done = 1'b1;
      applyStimulus();
      done = 1'b0;
      checkOutput("lit_ready_after_done", 128'(rd_ready), 128'(1));

      // Victim pointer wrap on set 2, read with done held from the start
      evict_adv = 1'b1; evict_adv_set = 2;
      stepN(L2_WAYS + 1);
      evict_adv = 1'b0;
      rd_valid = 1'b1; rd_set = 2; rd_mode = L2_LOOKUP; done = 1'b1;
      applyStimulus();
      rd_valid = 1'b0;
      stepN(4);
      checkOutput("lit_lookup_en_done", 128'(lookup_en),     128'(1));
      checkOutput("lit_evict_wrap",     128'(evict_way_buf), 128'(1));
      applyStimulus();
      done = 1'b0;
      checkOutput("lit_single_hold_ready",  128'(rd_ready),  128'(1));
      checkOutput("lit_single_hold_lookup", 128'(lookup_en), 128'(0));

      // Update of set 5 way 3 during WAIT overrides the RAM data
      rd_valid = 1'b1; rd_set = 5;
      applyStimulus();
      rd_valid = 1'b0;
      applyStimulus();
      upd_en = 1'b1; upd_set = 5; upd_way = 3; upd_tag = 8'h1A;
      upd_states = {SPX_R, SPX_R, SPX_R, SPX_R};
      applyStimulus();
      upd_en = 1'b0;
      stepN(2);
      checkOutput("lit_upd_lookup_en", 128'(lookup_en),  128'(1));
      checkOutput("lit_upd_tags",      128'(tags_buf),   128'(64'h575655541A525150));
      checkOutput("lit_upd_states",    128'(states_buf), 128'(64'h55555555AA555555));
      done = 1'b1;
      applyStimulus();
      done = 1'b0;

      // Reset in the middle of WAIT drops the request
      rd_valid = 1'b1; rd_set = 7; rd_mode = L2_LOOKUP_FWD;
      applyStimulus();
      rd_valid = 1'b0;
      applyStimulus();
      rst = 1'b0;
      applyStimulus();
      checkOutput("lit_midrst_ready", 128'(rd_ready),      128'(1));
      checkOutput("lit_midrst_rd_en", 128'(ram_rd_en),     128'(0));
      checkOutput("lit_midrst_tags",  128'(tags_buf),      128'(0));
      checkOutput("lit_midrst_mode",  128'(lookup_mode),   128'(0));
      rst = 1'b1;
      sawLookup = 1'b0;
      for (int i = 0; i < LAT + 3; i++) begin
         applyStimulus();
         if (lookup_en === 1'b1) sawLookup = 1'b1;
      end
      checkOutput("lit_midrst_no_lookup", 128'(sawLookup), 128'(0));
      rd_valid = 1'b1; rd_set = 5; rd_mode = L2_LOOKUP;
      applyStimulus();
      rd_valid = 1'b0;
      stepN(4);
      checkOutput("lit_after_rst_lookup", 128'(lookup_en), 128'(1));
      checkOutput("lit_after_rst_tags",   128'(tags_buf),  128'(64'h5756555453525150));
      done = 1'b1;
      applyStimulus();
      done = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 199) != 0);
         rd_valid      = ($urandom_range(0, 1) == 1);
         rd_set        = l2_set_t'($urandom_range(0, L2_SETS - 1));
         rd_tag        = l2_tag_t'($urandom());
         rd_mode       = ($urandom_range(0, 1) == 1);
         done          = ($urandom_range(0, 2) == 0);
         upd_en        = ($urandom_range(0, 4) < 2);
         upd_set       = ($urandom_range(0, 3) != 0) ? mSet : l2_set_t'($urandom_range(0, L2_SETS - 1));
         upd_way       = l2_way_t'($urandom_range(0, L2_WAYS - 1));
         upd_tag       = l2_tag_t'($urandom());
         upd_states    = 8'($urandom());
         evict_adv     = ($urandom_range(0, 2) == 0);
         evict_adv_set = ($urandom_range(0, 1) == 1) ? mSet : l2_set_t'($urandom_range(0, L2_SETS - 1));
         applyStimulus();
      end
      rst = 1'b1;
      clearInputs();
      stepN(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
